// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: dual write-back register file with per-register pending-write scoreboard and PC; define RV_REGFILE_BYPASS_EN for same-cycle write-to-read bypass
module rv_regfile_sb #(
    parameter int XLEN = 32,
    parameter int NUM_REGS = 32,
    parameter int AW = $clog2(NUM_REGS),
    parameter int PEND_W = 2,
    parameter logic [XLEN-1:0] PC_INIT_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_vld,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_rdy,
    input  logic            wba_en,
    input  logic [AW-1:0]   wba_addr,
    input  logic [XLEN-1:0] wba_data,
    input  logic            wbb_en,
    input  logic [AW-1:0]   wbb_addr,
    input  logic [XLEN-1:0] wbb_data,
    input  logic            pc_in_vld,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_inc,
    output logic [XLEN-1:0] pc_out
);
    localparam int CW = PEND_W + 1;
    localparam logic [AW:0] NR = (AW + 1)'(NUM_REGS);
    logic [XLEN-1:0] regs [NUM_REGS];
    logic [PEND_W-1:0] cnt [NUM_REGS];
    logic [PEND_W-1:0] cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] uf;
    logic [XLEN-1:0] pc;
    function automatic logic ok(input logic [AW-1:0] a);
        return a != '0 && {1'b0, a} < NR;
    endfunction
    function automatic logic [CW-1:0] dec_of(input logic [AW-1:0] a);
        return CW'(wba_en && ok(a) && wba_addr == a) + CW'(wbb_en && ok(a) && wbb_addr == a);
    endfunction
    function automatic logic [CW-1:0] sum_of(input int r);
        return {1'b0, cnt[r]} + CW'(iss_vld && iss_rdy && r != 0 && iss_rd == AW'(r));
    endfunction
    function automatic logic [XLEN-1:0] rd_data(input logic [AW-1:0] a);
`ifdef RV_REGFILE_BYPASS_EN
        return !ok(a) ? '0 : (wbb_en && wbb_addr == a) ? wbb_data : (wba_en && wba_addr == a) ? wba_data : regs[a];
`else
        return ok(a) ? regs[a] : '0;
`endif
    endfunction
    function automatic logic rd_busy(input logic [AW-1:0] a);
`ifdef RV_REGFILE_BYPASS_EN
        return ok(a) && {1'b0, cnt[a]} > dec_of(a);
`else
        return ok(a) && cnt[a] != '0;
`endif
    endfunction
    assign rs1_data = rd_data(rs1_addr);
    assign rs2_data = rd_data(rs2_addr);
    assign rs1_busy = rd_busy(rs1_addr);
    assign rs2_busy = rd_busy(rs2_addr);
    assign iss_rdy  = !ok(iss_rd) || cnt[iss_rd] != '1;
    assign pc_out   = pc;
    // underflow clamps at zero; the write itself still lands
    always_comb
        for (int r = 0; r < NUM_REGS; r++) begin
            uf[r] = sum_of(r) < dec_of(AW'(r));
            cnt_nxt[r] = uf[r] ? '0 : PEND_W'(sum_of(r) - dec_of(AW'(r)));
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                cnt[r] <= '0;
            end
            pc <= PC_INIT_ADDR;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
                regs[r] <= (wbb_en && ok(wbb_addr) && wbb_addr == AW'(r)) ? wbb_data :
                           (wba_en && ok(wba_addr) && wba_addr == AW'(r)) ? wba_data : regs[r];
            end
            pc <= pc_in_vld ? pc_in : pc_inc ? pc + XLEN'(4) : pc;
        end
    assert property (@(posedge clk) disable iff (!rst_n) uf == '0);
endmodule

// File: tb/tb_rv_regfile_sb.sv
// tb_rv_regfile_sb: directed and random checks of rv_regfile_sb against a behavioural model
module tb_rv_regfile_sb;
    localparam int NR = 32;
    logic clk = 0, rst_n = 0;
    logic [4:0] rs1_addr, rs2_addr, iss_rd, wba_addr, wbb_addr;
    logic [31:0] rs1_data, rs2_data, wba_data, wbb_data, pc_in, pc_out;
    logic rs1_busy, rs2_busy, iss_vld, iss_rdy, wba_en, wbb_en, pc_in_vld, pc_inc;
    int total = 0, bad = 0;
    logic [31:0] m_regs [NR];
    int m_cnt [NR];
    logic [31:0] m_pc;

    rv_regfile_sb #(.PC_INIT_ADDR(32'h8000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_vld(iss_vld), .iss_rd(iss_rd), .iss_rdy(iss_rdy),
        .wba_en(wba_en), .wba_addr(wba_addr), .wba_data(wba_data),
        .wbb_en(wbb_en), .wbb_addr(wbb_addr), .wbb_data(wbb_data),
        .pc_in_vld(pc_in_vld), .pc_in(pc_in), .pc_inc(pc_inc), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {iss_vld, wba_en, wbb_en, pc_in_vld, pc_inc} = '0;
        {rs1_addr, rs2_addr, iss_rd, wba_addr, wbb_addr} = '0;
        {wba_data, wbb_data, pc_in} = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_cnt[i] = 0;
        end
        m_pc = 32'h8000_0000;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
`ifdef RV_REGFILE_BYPASS_EN
        if (a != 0 && wbb_en && wbb_addr == a) return wbb_data;
        if (a != 0 && wba_en && wba_addr == a) return wba_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        int c = m_cnt[a];
`ifdef RV_REGFILE_BYPASS_EN
        if (wba_en && wba_addr == a) c--;
        if (wbb_en && wbb_addr == a) c--;
`endif
        return a != 0 && c > 0;
    endfunction

    // compare combinational outputs before the edge, then advance the model by one clock
    task automatic cycle();
        bit rdy;
        #1;
        rdy = (iss_rd == 0) || m_cnt[iss_rd] != 3;
        chk("rs1_data", rs1_data, exp_rd(rs1_addr));
        chk("rs2_data", rs2_data, exp_rd(rs2_addr));
        chk("rs1_busy", 32'(rs1_busy), 32'(exp_busy(rs1_addr)));
        chk("rs2_busy", 32'(rs2_busy), 32'(exp_busy(rs2_addr)));
        chk("iss_rdy", 32'(iss_rdy), 32'(rdy));
        chk("pc_out", pc_out, m_pc);
        @(posedge clk);
        if (iss_vld && rdy && iss_rd != 0) m_cnt[iss_rd]++;
        if (wba_en && wba_addr != 0) begin
            m_regs[wba_addr] = wba_data;
            if (m_cnt[wba_addr] > 0) m_cnt[wba_addr]--;
        end
        if (wbb_en && wbb_addr != 0) begin
            m_regs[wbb_addr] = wbb_data;
            if (m_cnt[wbb_addr] > 0) m_cnt[wbb_addr]--;
        end
        m_pc = pc_in_vld ? pc_in : pc_inc ? m_pc + 32'd4 : m_pc;
        @(negedge clk);
    endtask

    initial begin
        int avail [NR];
        idle();
        model_reset();
        #12;
        chk("rst_pc", pc_out, 32'h8000_0000);
        chk("rst_rs1_data", rs1_data, 32'h0);
        chk("rst_rs1_busy", 32'(rs1_busy), 32'h0);
        chk("rst_iss_rdy", 32'(iss_rdy), 32'h1);
        @(negedge clk);
        rst_n = 1;
        pc_inc = 1;
        repeat (3) cycle();
        pc_inc = 0;
        #1 chk("pc_inc3", pc_out, 32'h8000_000C);
        iss_vld = 1; iss_rd = 5;
        cycle();
        iss_vld = 0; rs1_addr = 5;
        #1 chk("busy5_set", 32'(rs1_busy), 32'h1);
        wba_en = 1; wba_addr = 5; wba_data = 32'hDEAD_BEEF;
        cycle();
        wba_en = 0;
        #1 chk("x5_data", rs1_data, 32'hDEAD_BEEF);
        chk("busy5_clr", 32'(rs1_busy), 32'h0);
        iss_vld = 1; iss_rd = 7;
        repeat (3) cycle();
        #1 chk("rdy_sat7", 32'(iss_rdy), 32'h0);
        wbb_en = 1; wbb_addr = 7; wbb_data = 32'h0000_0077;
        cycle();
        wbb_en = 0;
        #1 chk("rdy_after7", 32'(iss_rdy), 32'h1);
        iss_vld = 0;
        wba_en = 1; wba_addr = 7; wba_data = 32'h11;
        wbb_en = 1; wbb_addr = 7; wbb_data = 32'h22;
        cycle();
        idle();
        iss_vld = 1; iss_rd = 3;
        repeat (2) cycle();
        iss_vld = 0;
        wba_en = 1; wba_addr = 3; wba_data = 32'h1;
        wbb_en = 1; wbb_addr = 3; wbb_data = 32'h2;
        cycle();
        idle();
        rs1_addr = 3; rs2_addr = 7;
        #1 chk("x3_dual", rs1_data, 32'h2);
        chk("x3_busy", 32'(rs1_busy), 32'h0);
        chk("x7_dual", rs2_data, 32'h22);
        wba_en = 1; wba_addr = 0; wba_data = 32'hFFFF_FFFF;
        cycle();
        idle();
        #1 chk("x0_zero", rs1_data, 32'h0);
        pc_in_vld = 1; pc_inc = 1; pc_in = 32'h100;
        cycle();
        #1 chk("pc_redirect", pc_out, 32'h100);
        pc_inc = 0; pc_in = 32'hFFFF_FFFC;
        cycle();
        pc_in_vld = 0; pc_inc = 1;
        cycle();
        pc_inc = 0;
        #1 chk("pc_wrap", pc_out, 32'h0);
        iss_vld = 1; iss_rd = 9;
        cycle();
        idle();
        wba_en = 1; wba_addr = 9; wba_data = 32'h1234; rs2_addr = 9;
`ifdef RV_REGFILE_BYPASS_EN
        #1 chk("bypass_x9", rs2_data, 32'h1234);
`else
        #1 chk("nobypass_x9", rs2_data, 32'h0);
`endif
        cycle();
        idle();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) avail[i] = m_cnt[i];
            iss_vld = 1'($urandom);
            iss_rd = 5'($urandom_range(0, 7));
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            wba_addr = 5'($urandom_range(0, 7));
            wba_data = $urandom;
            wba_en = 1'($urandom) && (wba_addr == 0 || avail[wba_addr] > 0);
            if (wba_en && wba_addr != 0) avail[wba_addr]--;
            wbb_addr = 5'($urandom_range(0, 7));
            wbb_data = $urandom;
            wbb_en = 1'($urandom) && (wbb_addr == 0 || avail[wbb_addr] > 0);
            pc_in_vld = ($urandom % 8) == 0;
            pc_in = $urandom & 32'hFFFF_FFFC;
            pc_inc = 1'($urandom);
            cycle();
        end
        idle();
        iss_vld = 1; iss_rd = 4;
        cycle();
        idle();
        rs1_addr = 4;
        #1 rst_n = 0;
        #1 chk("mid_rst_pc", pc_out, 32'h8000_0000);
        chk("mid_rst_busy", 32'(rs1_busy), 32'h0);
        chk("mid_rst_data", rs1_data, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
